alu_rr_arbiter: RTL

- 16-way round-robin arbiter sharing the single ALU datapath among up to 16 requesters.
- Produces a registered 4-bit grant index that drives the 4-to-16 select decoder, plus a registered one-hot grant vector.
- A granted requester keeps the ALU while its request stays high, subject to an optional hold-limit timeout that forces rotation when others are waiting.
- Sits between requesting sub-blocks and the ALU operand/op muxes.

---
 rtl/alu_rr_arbiter_if.sv | 36 +++
 rtl/alu_rr_arbiter.sv | 138 +++++++++++++
 2 files changed

// File: rtl/alu_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_rr_arbiter_if
//  Purpose  : Request/grant bundle between ALU requesters and the
//             round-robin arbiter that owns the ALU operand/op muxes.
//  Revision : 1.0  initial release
// ============================================================================
interface alu_rr_arbiter_if #(
    parameter int N_REQ  = 16,
    parameter int HOLD_W = 4
) ();
    logic [N_REQ-1:0]  req;
    logic [N_REQ-1:0]  gnt;
    logic [3:0]        gnt_idx;
    logic              gnt_valid;
    logic [HOLD_W-1:0] hold_cnt;

    // Requester side: raises requests, observes grants.
    modport master (
        output req,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid,
        input  hold_cnt
    );

    // Arbiter side: samples requests, drives grants.
    modport slave (
        input  req,
        output gnt,
        output gnt_idx,
        output gnt_valid,
        output hold_cnt
    );
endinterface
`default_nettype wire

// File: rtl/alu_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : alu_rr_arbiter
//  Purpose  : 16-way round-robin arbiter for the shared ALU. Registered
//             one-hot grant plus 4-bit index for the select decoder. A
//             grantee keeps the ALU while requesting, unless it has held
//             for MAX_HOLD cycles while others wait (MAX_HOLD=0 disables).
//  Revision : 1.0  initial release
// ============================================================================
module alu_rr_arbiter #(
    parameter int N_REQ    = 16,
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 4
) (
    input  wire logic        clk,
    input  wire logic        reset,
    alu_rr_arbiter_if.slave  bus
);
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Value of hold_cnt on the last permitted cycle before forced rotation.
    localparam logic [HOLD_W-1:0] c_HOLD_LAST  = HOLD_W'(MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0] c_HOLD_SAT   = '1;
    localparam logic              c_TIMEOUT_EN = (MAX_HOLD != 0);

    state_t            state_q, state_d;
    logic [3:0]        ptr_q, ptr_d;
    logic [3:0]        idx_q, idx_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic              valid_q, valid_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    logic [N_REQ-1:0]  w_others;
    logic [4:0]        w_pick_all;
    logic [4:0]        w_pick_oth;
    logic              w_grant;
    logic [3:0]        w_win;

    // Circular priority search starting at 'start'; bit 4 flags a hit.
    // Scanning from the far end lets the nearest candidate overwrite last.
    function automatic logic [4:0] rr_pick(input logic [N_REQ-1:0] vec,
                                           input logic [3:0]       start);
        logic [4:0] res;
        logic [3:0] idx;
        res = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = start + 4'(k);
            if (vec[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // Next-state: arbitration, release hand-off, timeout rotation, hold count.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        idx_d      = idx_q;
        gnt_d      = gnt_q;
        valid_d    = valid_q;
        hold_d     = hold_q;
        w_grant    = 1'b0;
        w_win      = '0;
        // In BUSY gnt_q is exactly onehot(idx_q), so it masks the grantee.
        w_others   = bus.req & ~gnt_q;
        w_pick_all = rr_pick(bus.req, ptr_q);
        w_pick_oth = rr_pick(w_others, ptr_q);

        case (state_q)
            ST_IDLE: begin
                if (w_pick_all[4]) begin
                    w_grant = 1'b1;
                    w_win   = w_pick_all[3:0];
                end
            end
            ST_BUSY: begin
                if (!bus.req[idx_q]) begin
                    // Release: hand off without an idle gap if anyone waits.
                    if (w_pick_all[4]) begin
                        w_grant = 1'b1;
                        w_win   = w_pick_all[3:0];
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                        valid_d = 1'b0;
                        hold_d  = '0;
                    end
                end else if (c_TIMEOUT_EN && (hold_q == c_HOLD_LAST) && w_pick_oth[4]) begin
                    w_grant = 1'b1;
                    w_win   = w_pick_oth[3:0];
                end else if (hold_q != c_HOLD_SAT) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (w_grant) begin
            state_d = ST_BUSY;
            idx_d   = w_win;
            gnt_d   = N_REQ'(1) << w_win;
            valid_d = 1'b1;
            hold_d  = '0;
            ptr_d   = w_win + 4'd1;
        end
    end

    // State register; reset wins over any grant in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            gnt_q   <= '0;
            valid_q <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
            hold_q  <= hold_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = idx_q;
    assign bus.gnt_valid = valid_q;
    assign bus.hold_cnt  = hold_q;
endmodule
`default_nettype wire
